// File: rtl/sevenseg_pkg.sv
// Shared constants and helpers for the seven-segment display path.
// Contains the BCD digit limits, the direction encoding and the load clamp.
package sevenseg_pkg;

  localparam int         DIGIT_W  = 4;
  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_MIN  = 4'd0;
  localparam logic       DIR_UP   = 1'b1;
  localparam logic       DIR_DOWN = 1'b0;

  // Any non-BCD nibble (10..15) is forced to 9.
  function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] d);
    if (d > BCD_MAX) begin
      return BCD_MAX;
    end else begin
      return d;
    end
  endfunction

endpackage

// File: rtl/bcd_counter_n_if.sv
// Control and data bundle of the N-digit BCD counter.
// The BLANK vector is present only when BCD_COUNTER_BLANK_EN is defined.
interface bcd_counter_n_if #(
  parameter int DIGITS = 4
);

  logic                  CE;
  logic                  UP;
  logic                  LOAD;
  logic [4*DIGITS-1:0]   LOAD_VAL;
  logic [4*DIGITS-1:0]   BCD;
  logic                  TC;
  logic                  OVF;
`ifdef BCD_COUNTER_BLANK_EN
  logic [DIGITS-1:0]     BLANK;
`endif

  modport master (
    output CE, UP, LOAD, LOAD_VAL,
`ifdef BCD_COUNTER_BLANK_EN
    input  BLANK,
`endif
    input  BCD, TC, OVF
  );

  modport slave (
    input  CE, UP, LOAD, LOAD_VAL,
`ifdef BCD_COUNTER_BLANK_EN
    output BLANK,
`endif
    output BCD, TC, OVF
  );

endinterface

// File: rtl/bcd_digit_cell.sv
// Combinational single BCD digit step: increments or decrements one digit
// when cin_i is set and reports the carry/borrow to the next digit.
module bcd_digit_cell
  import sevenseg_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit_i,
  input  logic               cin_i,
  input  logic               up_i,
  output logic [DIGIT_W-1:0] digit_o,
  output logic               cout_o
);

  // Next digit value and carry/borrow out for one step request.
  always_comb begin
    digit_o = digit_i;
    cout_o  = 1'b0;
    if (!cin_i) begin
      digit_o = digit_i;
      cout_o  = 1'b0;
    end else if (up_i == DIR_UP) begin
      if (digit_i >= BCD_MAX) begin
        digit_o = BCD_MIN;
        cout_o  = 1'b1;
      end else begin
        digit_o = digit_i + 4'd1;
        cout_o  = 1'b0;
      end
    end else begin
      if (digit_i == BCD_MIN) begin
        digit_o = BCD_MAX;
        cout_o  = 1'b1;
      end else begin
        digit_o = digit_i - 4'd1;
        cout_o  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/bcd_counter_n.sv
// N-digit synchronous BCD up/down counter with load clamp, wrap/saturate,
// terminal-count pulse and sticky overflow. Optional BCD_COUNTER_BLANK_EN adds BLANK.
module bcd_counter_n
  import sevenseg_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic             CLK,
  input  logic             RESET,
  bcd_counter_n_if.slave   bus
);

  localparam int W = DIGIT_W * DIGITS;

  logic [W-1:0]    bcd_q;
  logic [W-1:0]    bcd_d;
  logic            tc_q;
  logic            tc_d;
  logic            ovf_q;
  logic            ovf_d;
  logic [W-1:0]    step_s;
  logic [W-1:0]    load_clamped_s;
  logic [DIGITS:0] carry_s;
  logic            term_s;

  // The step request enters digit 0 unconditionally; CE only selects the result.
  assign carry_s[0] = 1'b1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_cell
    bcd_digit_cell u_cell (
      .digit_i (bcd_q[g*DIGIT_W +: DIGIT_W]),
      .cin_i   (carry_s[g]),
      .up_i    (bus.UP),
      .digit_o (step_s[g*DIGIT_W +: DIGIT_W]),
      .cout_o  (carry_s[g+1])
    );
  end

  // A carry out of the top digit means all 9s (up) or all 0s (down).
  assign term_s = carry_s[DIGITS];

  // Clamp each load nibble into the BCD range.
  always_comb begin
    load_clamped_s = '0;
    for (int i = 0; i < DIGITS; i++) begin
      load_clamped_s[i*DIGIT_W +: DIGIT_W] = clamp_digit(bus.LOAD_VAL[i*DIGIT_W +: DIGIT_W]);
    end
  end

  // Next-state selection: LOAD over CE, terminal handling for wrap/saturate.
  always_comb begin
    bcd_d = bcd_q;
    tc_d  = 1'b0;
    ovf_d = ovf_q;
    if (bus.LOAD) begin
      bcd_d = load_clamped_s;
      tc_d  = 1'b0;
      ovf_d = 1'b0;
    end else if (bus.CE) begin
      if (term_s && SATURATE) begin
        bcd_d = bcd_q;
      end else begin
        bcd_d = step_s;
      end
      tc_d = term_s;
      if (term_s) begin
        ovf_d = 1'b1;
      end else begin
        ovf_d = ovf_q;
      end
    end else begin
      bcd_d = bcd_q;
      tc_d  = 1'b0;
      ovf_d = ovf_q;
    end
  end

  // Count, terminal-count and overflow registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      bcd_q <= '0;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      bcd_q <= bcd_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end

  assign bus.BCD = bcd_q;
  assign bus.TC  = tc_q;
  assign bus.OVF = ovf_q;

`ifdef BCD_COUNTER_BLANK_EN
  localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1'b1);

  logic [DIGITS-1:0] blank_q;
  logic [DIGITS-1:0] blank_d;
  logic              higher_zero_s;

  // Leading-zero blanking of the next value; the ones digit always shows.
  always_comb begin
    blank_d       = '0;
    higher_zero_s = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (bcd_d[i*DIGIT_W +: DIGIT_W] == BCD_MIN) begin
        higher_zero_s = higher_zero_s;
      end else begin
        higher_zero_s = 1'b0;
      end
      blank_d[i] = higher_zero_s;
    end
    blank_d[0] = 1'b0;
  end

  // Blanking register, updated alongside the count.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      blank_q <= BLANK_RST;
    end else begin
      blank_q <= blank_d;
    end
  end

  assign bus.BLANK = blank_q;
`endif

endmodule

// File: tb/tb_bcd_counter_n.sv
// Directed self-checking bench: a wrapping and a saturating 4-digit counter
// driven with identical stimulus and checked against hand-computed values.
module tb_bcd_counter_n;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        ce;
  logic        up;
  logic        load;
  logic [15:0] load_val;

  int errors = 0;
  int checks = 0;

  logic [15:0] bcd_s [2];
  logic        tc_s  [2];
  logic        ovf_s [2];
`ifdef BCD_COUNTER_BLANK_EN
  logic [3:0]  blank_s [2];
`endif

  always #5 CLK = ~CLK;

  bcd_counter_n_if #(.DIGITS(4)) bus0 ();
  bcd_counter_n_if #(.DIGITS(4)) bus1 ();

  assign bus0.CE = ce;   assign bus0.UP = up;
  assign bus0.LOAD = load; assign bus0.LOAD_VAL = load_val;
  assign bus1.CE = ce;   assign bus1.UP = up;
  assign bus1.LOAD = load; assign bus1.LOAD_VAL = load_val;

  bcd_counter_n #(.DIGITS(4), .SATURATE(1'b0)) dut0 (.CLK(CLK), .RESET(RESET), .bus(bus0.slave));
  bcd_counter_n #(.DIGITS(4), .SATURATE(1'b1)) dut1 (.CLK(CLK), .RESET(RESET), .bus(bus1.slave));

  // One clock edge, then capture both counters away from the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
    bcd_s[0] = bus0.BCD;  tc_s[0] = bus0.TC;  ovf_s[0] = bus0.OVF;
    bcd_s[1] = bus1.BCD;  tc_s[1] = bus1.TC;  ovf_s[1] = bus1.OVF;
`ifdef BCD_COUNTER_BLANK_EN
    blank_s[0] = bus0.BLANK;
    blank_s[1] = bus1.BLANK;
`endif
  endtask

  task automatic test_reset();
    RESET = 1'b1; ce = 1'b1; up = 1'b1; load = 1'b0; load_val = 16'h0000;
    tick();
    RESET = 1'b0;
    for (int d = 0; d < 2; d++) begin
      checks++; if (bcd_s[d] !== 16'h0000) begin errors++; $display("FAIL reset_bcd dut%0d got %h want 0000", d, bcd_s[d]); end
      checks++; if (tc_s[d] !== 1'b0) begin errors++; $display("FAIL reset_tc dut%0d got %b want 0", d, tc_s[d]); end
      checks++; if (ovf_s[d] !== 1'b0) begin errors++; $display("FAIL reset_ovf dut%0d got %b want 0", d, ovf_s[d]); end
`ifdef BCD_COUNTER_BLANK_EN
      checks++; if (blank_s[d] !== 4'b1110) begin errors++; $display("FAIL reset_blank dut%0d got %b want 1110", d, blank_s[d]); end
`endif
    end
  endtask

  task automatic test_count_up();
    logic [15:0] exp;
    ce = 1'b1; up = 1'b1;
    for (int s = 1; s <= 12; s++) begin
      tick();
      exp = (s < 10) ? 16'(s) : 16'(16 + s - 10);
      for (int d = 0; d < 2; d++) begin
        checks++; if (bcd_s[d] !== exp) begin errors++; $display("FAIL count_bcd dut%0d step %0d got %h want %h", d, s, bcd_s[d], exp); end
        checks++; if (tc_s[d] !== 1'b0 || ovf_s[d] !== 1'b0) begin errors++; $display("FAIL count_flags dut%0d step %0d got tc=%b ovf=%b want 0 0", d, s, tc_s[d], ovf_s[d]); end
      end
    end
    ce = 1'b0;
  endtask

  task automatic test_wrap_saturate();
    logic [15:0] e0 [3] = '{16'h9999, 16'h0000, 16'h0001};
    logic        t0 [3] = '{1'b0, 1'b1, 1'b0};
    logic        t1 [3] = '{1'b0, 1'b1, 1'b1};
    logic        ov [3] = '{1'b0, 1'b1, 1'b1};
    load = 1'b1; load_val = 16'h9998; ce = 1'b0;
    tick();
    load = 1'b0;
    checks++; if (bcd_s[0] !== 16'h9998) begin errors++; $display("FAIL wrap_load got %h want 9998", bcd_s[0]); end
    ce = 1'b1; up = 1'b1;
    for (int s = 0; s < 3; s++) begin
      tick();
      checks++; if (bcd_s[0] !== e0[s]) begin errors++; $display("FAIL wrap_bcd step %0d got %h want %h", s, bcd_s[0], e0[s]); end
      checks++; if (bcd_s[1] !== 16'h9999) begin errors++; $display("FAIL sat_bcd step %0d got %h want 9999", s, bcd_s[1]); end
      checks++; if (tc_s[0] !== t0[s]) begin errors++; $display("FAIL wrap_tc step %0d got %b want %b", s, tc_s[0], t0[s]); end
      checks++; if (tc_s[1] !== t1[s]) begin errors++; $display("FAIL sat_tc step %0d got %b want %b", s, tc_s[1], t1[s]); end
      for (int d = 0; d < 2; d++) begin
        checks++; if (ovf_s[d] !== ov[s]) begin errors++; $display("FAIL wrap_ovf dut%0d step %0d got %b want %b", d, s, ovf_s[d], ov[s]); end
      end
    end
    ce = 1'b0;
    tick();
    for (int d = 0; d < 2; d++) begin
      checks++; if (tc_s[d] !== 1'b0 || ovf_s[d] !== 1'b1) begin errors++; $display("FAIL idle_after_tc dut%0d got tc=%b ovf=%b want 0 1", d, tc_s[d], ovf_s[d]); end
    end
    checks++; if (bcd_s[0] !== 16'h0001) begin errors++; $display("FAIL hold_bcd got %h want 0001", bcd_s[0]); end
  endtask

  task automatic test_count_down();
    logic [15:0] e0 [2] = '{16'h0000, 16'h9999};
    logic        tt [2] = '{1'b0, 1'b1};
    load = 1'b1; load_val = 16'h0001;
    tick();
    load = 1'b0; ce = 1'b1; up = 1'b0;
    for (int s = 0; s < 2; s++) begin
      tick();
      checks++; if (bcd_s[0] !== e0[s]) begin errors++; $display("FAIL down_bcd step %0d got %h want %h", s, bcd_s[0], e0[s]); end
      checks++; if (bcd_s[1] !== 16'h0000) begin errors++; $display("FAIL down_sat_bcd step %0d got %h want 0000", s, bcd_s[1]); end
      for (int d = 0; d < 2; d++) begin
        checks++; if (tc_s[d] !== tt[s] || ovf_s[d] !== tt[s]) begin errors++; $display("FAIL down_flags dut%0d step %0d got tc=%b ovf=%b want %b %b", d, s, tc_s[d], ovf_s[d], tt[s], tt[s]); end
      end
    end
    ce = 1'b0; load = 1'b1; load_val = 16'h0500;
    tick();
    load = 1'b0;
    for (int d = 0; d < 2; d++) begin
      checks++; if (bcd_s[d] !== 16'h0500 || ovf_s[d] !== 1'b0 || tc_s[d] !== 1'b0) begin errors++; $display("FAIL load_clear dut%0d got bcd=%h tc=%b ovf=%b want 0500 0 0", d, bcd_s[d], tc_s[d], ovf_s[d]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] ex [3] = '{16'h0099, 16'h0100, 16'h0099};
    logic        dir [3] = '{1'b0, 1'b1, 1'b0};
    load = 1'b1; load_val = 16'h0100;
    tick();
    load = 1'b0; ce = 1'b1;
    for (int s = 0; s < 3; s++) begin
      up = dir[s];
      tick();
      checks++; if (bcd_s[0] !== ex[s]) begin errors++; $display("FAIL dirchg_bcd step %0d got %h want %h", s, bcd_s[0], ex[s]); end
    end
    ce = 1'b0;
    tick();
    checks++; if (bcd_s[1] !== 16'h0099 || tc_s[1] !== 1'b0) begin errors++; $display("FAIL dirchg_hold got bcd=%h tc=%b want 0099 0", bcd_s[1], tc_s[1]); end
  endtask

  task automatic test_load_clamp_reset();
    load = 1'b1; ce = 1'b1; up = 1'b1; load_val = 16'h1A3F;
    tick();
    load = 1'b0;
    for (int d = 0; d < 2; d++) begin
      checks++; if (bcd_s[d] !== 16'h1939 || tc_s[d] !== 1'b0) begin errors++; $display("FAIL clamp dut%0d got bcd=%h tc=%b want 1939 0", d, bcd_s[d], tc_s[d]); end
    end
    tick();
    checks++; if (bcd_s[0] !== 16'h1940) begin errors++; $display("FAIL clamp_step got %h want 1940", bcd_s[0]); end
    load = 1'b1; load_val = 16'h9999;
    tick();
    load = 1'b0;
    tick();
    checks++; if (bcd_s[0] !== 16'h0000 || ovf_s[0] !== 1'b1 || tc_s[0] !== 1'b1) begin errors++; $display("FAIL pre_reset got bcd=%h tc=%b ovf=%b want 0000 1 1", bcd_s[0], tc_s[0], ovf_s[0]); end
    RESET = 1'b1; load = 1'b1; load_val = 16'h4321;
    tick();
    RESET = 1'b0; load = 1'b0; ce = 1'b0;
    for (int d = 0; d < 2; d++) begin
      checks++; if (bcd_s[d] !== 16'h0000 || tc_s[d] !== 1'b0 || ovf_s[d] !== 1'b0) begin errors++; $display("FAIL midcount_reset dut%0d got bcd=%h tc=%b ovf=%b want 0000 0 0", d, bcd_s[d], tc_s[d], ovf_s[d]); end
    end
  endtask

`ifdef BCD_COUNTER_BLANK_EN
  task automatic test_blank();
    logic [15:0] lv [3] = '{16'h0040, 16'h0000, 16'h1000};
    logic [3:0]  eb [3] = '{4'b1100, 4'b1110, 4'b0000};
    for (int s = 0; s < 3; s++) begin
      load = 1'b1; load_val = lv[s];
      tick();
      checks++; if (blank_s[0] !== eb[s]) begin errors++; $display("FAIL blank load %h got %b want %b", lv[s], blank_s[0], eb[s]); end
    end
    load = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_count_up();
    test_wrap_saturate();
    test_count_down();
    test_back_to_back();
    test_load_clamp_reset();
`ifdef BCD_COUNTER_BLANK_EN
    test_blank();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
